mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single-port unified memory between two requesters: instruction fetch (port I) and load/store (port D).
- Also formats byte, half and word accesses into lane-aligned memory operations. Examples: SH to addr 0x2002 becomes mem_be=1100; LB data is shifted down to bits [7:0].
- Sits between the core pipeline and the memory array. It replaces direct core-to-memory wiring so that riscv-tests programs (rv32ui sb/sh/sw/lb/lh/lw) run through one arbitrated path.

Parameters:
ADDR_W, 16, word-address width of the memory array (byte address space = 2^(ADDR_W+2)).
MAX_D_BURST, 4, maximum consecutive D grants while if_req is pending before I must be granted.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
if_req  input  1  fetch request; held high with if_addr stable until if_gnt
if_addr  input  32  fetch byte address (word aligned)
if_gnt  output  1  one-cycle pulse: fetch request accepted
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  32  fetched instruction word
d_req  input  1  data request; held with d_* stable until d_gnt
d_we  input  1  1 = store, 0 = load
d_size  input  2  00 byte, 01 half, 10 word; 11 illegal
d_addr  input  32  data byte address
d_wdata  input  32  store data, right-aligned
d_gnt  output  1  one-cycle pulse: data request accepted
d_rvalid  output  1  one-cycle pulse: load data / store ack / error valid
d_rdata  output  32  load data, right-aligned, zero-extended (core sign-extends)
d_err  output  1  qualifies d_rvalid: misaligned, illegal size, or out of range
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_be  output  4  byte-lane write enables
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  lane-replicated write data
mem_rdata  input  32  read data; valid the cycle after mem_en && !mem_we

Behaviour:
- FSM: IDLE, ACCESS, RESP. All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE, burst counter=0, all outputs 0. Any in-flight transaction is dropped and no rvalid is ever produced for it.
- Arbitration (evaluated in IDLE, and in RESP for back-to-back):
  - D has priority over I.
  - Exception: I wins if if_req=1 and burst_cnt==MAX_D_BURST.
  - Grant sets winner's gnt=1 at the next edge and enters ACCESS.
- Burst counter:
  - Increments on each D grant while if_req=1 (saturates at MAX_D_BURST).
  - Clears on any I grant, and when if_req=0 at a D grant.
- Cycle timing: req seen in cycle 0 -> gnt and mem_* driven in cycle 1 (ACCESS) -> rvalid and rdata in cycle 2 (RESP). If another req is pending in RESP, the next gnt is also in cycle 2, so the pipeline sustains one access every 2 cycles.
- ACCESS:
  - mem_en=1 and mem_addr=addr[ADDR_W+1:2].
  - Load: mem_we=0.
  - Store: mem_we=1 with byte enables:
    - Byte: mem_be=0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
    - Half: mem_be=0011<<addr[1:0], mem_wdata={2{wdata[15:0]}}.
    - Word: mem_be=1111, mem_wdata=wdata.
  - Fetch is always a word read.
- RESP:
  - Load: d_rdata = (mem_rdata >> 8*addr[1:0]), masked to 8/16/32 bits.
  - Fetch: if_rdata = mem_rdata.
  - Store: d_rvalid=1, d_rdata=0 (acknowledge).
- Error cases: half with addr[0]=1; word with addr[1:0]!=0; d_size=11; or addr[31:ADDR_W+2]!=0.
  - Request is still granted, but mem_en stays 0 in ACCESS.
  - RESP gives d_rvalid=1, d_err=1, d_rdata=0.
  - No memory write may occur.
- Fetch error (misaligned or out of range): same flow, if_rvalid=1 with if_rdata=0x00000013 (NOP). Port I has no error output.
- Simultaneous I and D requests: exactly one gnt per cycle; the loser keeps its req and is served next.
- A requester deasserting req before gnt is a protocol violation; behaviour is undefined but must not hang the FSM.

Test Plan:
- Load path: mem word 0x100 = 0x11223344; LH addr 0x402 -> d_gnt at cycle 1, d_rvalid at cycle 2, d_rdata=0x00001122, d_err=0.
- Store path: SH addr 0x2002, wdata=0x0000BEEF -> mem_we=1, mem_be=1100, mem_addr=0x800, mem_wdata=0xBEEFBEEF; subsequent LW returns 0xBEEFxxxx with the low half unchanged.
- Arbitration: if_req and d_req held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; no I starvation, burst_cnt returns to 0 after each I grant.
- Errors: SH addr 0x1001 -> d_err=1, mem_en never asserted, memory unchanged. LW addr 0x00040000 (out of range, ADDR_W=16) -> d_err=1.
- Reset: rst=0 during ACCESS of a store -> all outputs 0 immediately; no rvalid after release; memory not written if reset lands before the ACCESS edge; FSM restarts cleanly in IDLE.
- Fetch stream: if_req alone at addrs 0x0, 0x4, 0x8 -> if_rvalid every 2 cycles with correct words; fetch of 0x3 -> if_rdata=0x00000013.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter and lane formatter for a single-port unified memory

module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam int CW = $clog2(MAX_D_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_D_BURST);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   burst_q;

    logic            arb_ok;
    logic            grant_i;
    logic            grant_d;

    logic            d_err_c;
    logic            i_err_c;
    logic [3:0]      d_be_c;
    logic [31:0]     d_wdata_c;

    // Transaction captured at grant time, consumed when the response is formed.
    logic            txn_d;
    logic            txn_we;
    logic [1:0]      txn_size;
    logic [1:0]      txn_off;
    logic            txn_err;

    logic [31:0]     ld_shift;
    logic [31:0]     ld_fmt;

    // Arbitration: D wins unless I has waited out a full D burst.
    always_comb begin
        arb_ok  = (state_q == S_IDLE) || (state_q == S_RESP);
        grant_i = arb_ok && if_req && (!d_req || (burst_q == BURST_MAX));
        grant_d = arb_ok && d_req && !grant_i;
    end

    // Error classification for both ports: alignment, size encoding and range.
    always_comb begin
        d_err_c = 1'b0;
        case (d_size)
            2'b00:   d_err_c = 1'b0;
            2'b01:   d_err_c = d_addr[0];
            2'b10:   d_err_c = (d_addr[1:0] != 2'b00);
            default: d_err_c = 1'b1;
        endcase
        if ((d_addr >> (ADDR_W + 2)) != 32'h0) begin
            d_err_c = 1'b1;
        end
        i_err_c = (if_addr[1:0] != 2'b00) || ((if_addr >> (ADDR_W + 2)) != 32'h0);
    end

    // Store lane formatting: byte enables and replicated write data.
    always_comb begin
        d_be_c    = 4'b0000;
        d_wdata_c = 32'h0;
        case (d_size)
            2'b00: begin
                d_be_c    = 4'b0001 << d_addr[1:0];
                d_wdata_c = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be_c    = 4'b0011 << d_addr[1:0];
                d_wdata_c = {2{d_wdata[15:0]}};
            end
            default: begin
                d_be_c    = 4'b1111;
                d_wdata_c = d_wdata;
            end
        endcase
    end

    // Next-state logic: a grant always leads into ACCESS, ACCESS always into RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = (grant_i || grant_d) ? S_ACCESS : S_IDLE;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = (grant_i || grant_d) ? S_ACCESS : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst counter: tracks consecutive D grants made while a fetch is waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_q <= '0;
        end else if (grant_i) begin
            burst_q <= '0;
        end else if (grant_d) begin
            if (!if_req) begin
                burst_q <= '0;
            end else if (burst_q != BURST_MAX) begin
                burst_q <= burst_q + CW'(1);
            end
        end
    end

    // Registered grant, memory strobe and response-valid outputs plus transaction capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            txn_d     <= 1'b0;
            txn_we    <= 1'b0;
            txn_size  <= 2'b00;
            txn_off   <= 2'b00;
            txn_err   <= 1'b0;
        end else begin
            if_gnt    <= grant_i;
            d_gnt     <= grant_d;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            if (grant_d) begin
                mem_en   <= !d_err_c;
                mem_addr <= d_err_c ? '0 : d_addr[ADDR_W+1:2];
                if (d_we && !d_err_c) begin
                    mem_we    <= 1'b1;
                    mem_be    <= d_be_c;
                    mem_wdata <= d_wdata_c;
                end
                txn_d    <= 1'b1;
                txn_we   <= d_we;
                txn_size <= d_size;
                txn_off  <= d_addr[1:0];
                txn_err  <= d_err_c;
            end else if (grant_i) begin
                mem_en   <= !i_err_c;
                mem_addr <= i_err_c ? '0 : if_addr[ADDR_W+1:2];
                txn_d    <= 1'b0;
                txn_we   <= 1'b0;
                txn_size <= 2'b10;
                txn_off  <= 2'b00;
                txn_err  <= i_err_c;
            end
            if_rvalid <= (state_q == S_ACCESS) && !txn_d;
            d_rvalid  <= (state_q == S_ACCESS) && txn_d;
            d_err     <= (state_q == S_ACCESS) && txn_d && txn_err;
        end
    end

    // Read data arrives the same cycle as rvalid, so it is formatted from registered controls.
    always_comb begin
        ld_shift = mem_rdata >> {txn_off, 3'b000};
        case (txn_size)
            2'b00:   ld_fmt = {24'h0, ld_shift[7:0]};
            2'b01:   ld_fmt = {16'h0, ld_shift[15:0]};
            default: ld_fmt = ld_shift;
        endcase
        d_rdata  = (d_rvalid && !txn_err && !txn_we) ? ld_fmt : 32'h0;
        if_rdata = !if_rvalid ? 32'h0 : (txn_err ? NOP_INSN : mem_rdata);
    end

endmodule
